// File: rtl/rvi_bits_issue_pkg.sv
// rvi_bits_issue_pkg: RVI opcode/funct constants and the bitwise op encoding shared by the issue stage
package rvi_bits_issue_pkg;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [2:0] F3_AND      = 3'b111;
  localparam logic [2:0] F3_OR       = 3'b110;
  localparam logic [2:0] F3_XOR      = 3'b100;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  typedef enum logic [1:0] {AND, OR, XOR, NONE} BitsOp_e;
  function automatic BitsOp_e f3_op(input logic [2:0] f3);
    return f3 == F3_AND ? AND : f3 == F3_OR ? OR : f3 == F3_XOR ? XOR : NONE;
  endfunction
endpackage

// File: rtl/rvi_bits_issue_if.sv
// rvi_bits_issue_if: issue-stage bundle; i* = into the stage, o* = out of the stage
//   master: upstream/downstream side (drives iValid/iInst/iRs*Data/iFlush/iReady)
//   slave : the issue stage (drives oReady/oValid/oS1/oS2/enables/oRd/oNotBits)
interface rvi_bits_issue_if #(parameter int CPU_WIDTH = 32);
  logic iValid, oReady, iFlush, oValid, iReady, oAndEn, oOrEn, oXorEn, oNotBits;
  logic [31:0] iInst;
  logic [CPU_WIDTH-1:0] iRs1Data, iRs2Data, oS1, oS2;
  logic [4:0] oRd;
  modport master (
    output iValid, iInst, iRs1Data, iRs2Data, iFlush, iReady,
    input  oReady, oValid, oS1, oS2, oAndEn, oOrEn, oXorEn, oRd, oNotBits
  );
  modport slave (
    input  iValid, iInst, iRs1Data, iRs2Data, iFlush, iReady,
    output oReady, oValid, oS1, oS2, oAndEn, oOrEn, oXorEn, oRd, oNotBits
  );
endinterface

// File: rtl/rvi_bits_skid_reg.sv
// rvi_bits_skid_reg: 2-entry (main + skid) valid/ready register with synchronous flush
//   in_valid/in_ready/in_data: upstream side, in_ready is registered (= !skid valid)
//   out_valid/out_ready/out_data: downstream side, driven straight from the main entry
module rvi_bits_skid_reg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic skid_valid, acc, pop;
  logic [W-1:0] skid_data;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  // in_ready tracks !skid_valid as its own flop so iReady never reaches it combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (skid_valid) begin
      if (pop) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end
    end else if (acc && (!out_valid || pop)) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (acc) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/rvi_bits_issue.sv
// rvi_bits_issue: decodes AND/OR/XOR(+I) and issues s1/s2/one-hot enables through a skid register
//   clk, rst (async, active-high); bus: rvi_bits_issue_if slave modport
//   non-bitwise instructions are accepted, dropped, and flagged by a one-cycle oNotBits pulse
module rvi_bits_issue
  import rvi_bits_issue_pkg::*;
#(
  parameter int RV64 = 0,
  localparam int CPU_WIDTH = 32 * (RV64 + 1)
) (
  input logic clk,
  input logic rst,
  rvi_bits_issue_if.slave bus
);
  typedef struct packed {
    logic [CPU_WIDTH-1:0] s1;
    logic [CPU_WIDTH-1:0] s2;
    BitsOp_e              op;
    logic [4:0]           rd;
  } BitsUop_t;
  BitsUop_t dec, head;
  logic is_op, is_imm, is_bits, main_valid;
  always_comb begin
    is_op   = bus.iInst[6:0] == OPC_OP && bus.iInst[31:25] == FUNCT7_BASE;
    is_imm  = bus.iInst[6:0] == OPC_OPIMM;
    dec.op  = (is_op || is_imm) ? f3_op(bus.iInst[14:12]) : NONE;
    dec.s1  = bus.iRs1Data;
    dec.s2  = is_imm ? {{(CPU_WIDTH-12){bus.iInst[31]}}, bus.iInst[31:20]} : bus.iRs2Data;
    dec.rd  = bus.iInst[11:7];
    is_bits = dec.op != NONE;
  end
  rvi_bits_skid_reg #(.W($bits(BitsUop_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.iFlush),
    .in_valid  (bus.iValid && is_bits),
    .in_ready  (bus.oReady),
    .in_data   (dec),
    .out_valid (main_valid),
    .out_ready (bus.iReady),
    .out_data  (head)
  );
  // a flushed transfer-in is discarded together with its drop notification
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.oNotBits <= 1'b0;
    else bus.oNotBits <= bus.iValid && bus.oReady && !is_bits && !bus.iFlush;
  assign bus.oValid = main_valid;
  assign bus.oS1    = head.s1;
  assign bus.oS2    = head.s2;
  assign bus.oRd    = head.rd;
  assign bus.oAndEn = main_valid && head.op == AND;
  assign bus.oOrEn  = main_valid && head.op == OR;
  assign bus.oXorEn = main_valid && head.op == XOR;
endmodule

// File: doc/rvi_bits_issue.md
# rvi_bits_issue

Issue stage directly upstream of the RVI bitwise execute unit. Accepts one 32-bit instruction per cycle with its register-file operands, decodes AND/OR/XOR/ANDI/ORI/XORI, forms the s1/s2 operands and one-hot enables, and presents them through a 2-entry skid-buffered valid/ready pipeline register. The outputs drive the bitwise execute unit's s1, s2, andEn, orEn and xorEn inputs unmodified.

## Interface
- RV64, 0, 1 selects 64-bit datapath.
- CPU_WIDTH, 32*(RV64+1), derived operand width; not overridden.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- iValid  in  1  upstream instruction valid.
- oReady  out  1  stage can accept; registered, equals !skidValid.
- iInst  in  32  raw instruction.
- iRs1Data  in  CPU_WIDTH  rs1 value.
- iRs2Data  in  CPU_WIDTH  rs2 value; ignored for immediate forms.
- iFlush  in  1  synchronous flush of all held entries.
- oValid  out  1  issued op valid.
- iReady  in  1  downstream accepts.
- oS1  out  CPU_WIDTH  operand 1.
- oS2  out  CPU_WIDTH  operand 2 or sign-extended immediate.
- oAndEn, oOrEn, oXorEn  out  1 each  one-hot op enables; all 0 when !oValid.
- oRd  out  5  destination register.
- oNotBits  out  1  one-cycle pulse: accepted instruction was not a bitwise op and was dropped.

## Operation
- Transfer in: iValid && oReady. Transfer out: oValid && iReady.
- Decode, on iInst: opcode = [6:0], funct3 = [14:12], funct7 = [31:25].
  - OP (0110011) with funct7 = 0000000: funct3 111 AND, 110 OR, 100 XOR; s2 = iRs2Data.
  - OP-IMM (0010011): funct3 111 ANDI, 110 ORI, 100 XORI; s2 = imm[11:0] from iInst[31:20], sign-extended to CPU_WIDTH.
  - s1 = iRs1Data always; rd = iInst[11:7].
  - Anything else is accepted, not stored, and pulses oNotBits on the next cycle.
- Two entries, main and skid.
  - Main drives the outputs.
  - Skid captures an accepted bitwise op when main is valid and !iReady.
  - When main drains and skid is valid, skid moves to main and new input is blocked that cycle (oReady = 0).
- Order is preserved. No entry is duplicated or lost.
- Flush:
  - Clears main valid and skid valid at the next edge.
  - A transfer-in in the same cycle is discarded, and so is its oNotBits.
  - A transfer-out in the same cycle completes normally; downstream samples before the edge.
- Enables are forced to 0 whenever oValid = 0.

## Timing
- Reset: oValid = 0, oReady = 1, oNotBits = 0, enables = 0, oS1 = oS2 = 0, oRd = 0, both entries invalid. Reset asserted mid-stream discards all entries immediately.
- Latency: instruction accepted at edge N appears on the outputs after edge N; consumable at edge N+1.
- Throughput: one per cycle while iReady = 1.
- Backpressure:
  - iReady low with main full: one more op is absorbed into skid, then oReady falls at the following edge.
  - oReady rises one cycle after skid drains.
- Simultaneous in/out with main full and skid empty: main is replaced by the new op. Skid stays empty.
- Outputs are all registered. There is no combinational path from iReady to oReady.

## Structure
- Package rvi_bits_issue_pkg:
  - OPC_OP, OPC_OPIMM.
  - F3_AND, F3_OR, F3_XOR.
  - FUNCT7_BASE.
  - typedef enum BitsOp_e {AND, OR, XOR, NONE}.
  - Packed struct BitsUop_t: s1, s2, op, rd, parameterised via CPU_WIDTH-sized fields in the module.
- Sub-module rvi_bits_skid_reg: generic 2-entry valid/ready skid register over a payload of width W, with flush. The decoder stays combinational in the top.

## Test plan
- Reset, then no input for 5 cycles -> oValid = 0, oReady = 1, oNotBits = 0 throughout.
- RV64=0: AND x3 (iInst 0x0020F1B3), iRs1Data 0xF0F0_00FF, iRs2Data 0x0FF0_0F0F, iReady = 1 -> next cycle oValid = 1, oAndEn = 1, oS2 = 0x0FF0_0F0F, oRd = 3.
- RV64=1: XORI imm = -1 (iInst 0xFFF14093) -> oXorEn = 1, oS2 = 0xFFFF_FFFF_FFFF_FFFF, oRd = 1.
- Back-to-back ORI/ANDI/XOR, iReady held low for 3 cycles:
  - oReady falls after the second op.
  - After release, the ops are issued in order with no loss or duplication.
- ADD (iInst 0x002081B3) accepted -> no oValid; oNotBits = 1 for exactly one cycle.
- Main and skid full, then iFlush = 1 with iValid = 1 -> next cycle oValid = 0, oReady = 1; the flushed-cycle input never appears.
